// File: rtl/alu_op_scheduler_if.sv
// Request/response and ALU-side signal bundle for alu_op_scheduler.
// Handshake: a requester raises ReqN_Valid with ReqN_Op and holds both stable until
// ReqN_Ready pulses for one cycle (transfer happens in that cycle); RspN_Valid is a
// one-cycle strobe with no backpressure, carrying RspN_Data and Rsp_Err.
interface alu_op_scheduler_if #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
);
  logic              Req0_Valid;
  logic [SEL_W-1:0]  Req0_Op;
  logic              Req0_Ready;
  logic              Rsp0_Valid;
  logic [DATA_W-1:0] Rsp0_Data;
  logic              Req1_Valid;
  logic [SEL_W-1:0]  Req1_Op;
  logic              Req1_Ready;
  logic              Rsp1_Valid;
  logic [DATA_W-1:0] Rsp1_Data;
  logic              Rsp_Err;
  logic [SEL_W-1:0]  Alu_Select;
  logic              Alu_Flag;
  logic [DATA_W-1:0] Alu_Result;
  logic              Busy;
  logic [1:0]        Dbg_State;

  modport master (
    output Req0_Valid, Req0_Op, Req1_Valid, Req1_Op, Alu_Result,
    input  Req0_Ready, Rsp0_Valid, Rsp0_Data, Req1_Ready, Rsp1_Valid, Rsp1_Data,
    input  Rsp_Err, Alu_Select, Alu_Flag, Busy, Dbg_State
  );

  modport slave (
    input  Req0_Valid, Req0_Op, Req1_Valid, Req1_Op, Alu_Result,
    output Req0_Ready, Rsp0_Valid, Rsp0_Data, Req1_Ready, Rsp1_Valid, Rsp1_Data,
    output Rsp_Err, Alu_Select, Alu_Flag, Busy, Dbg_State
  );
endinterface

// File: rtl/alu_op_scheduler.sv
// Two-requester scheduler for the shared ALU result mux: arbitrates, issues one op at a
// time, waits LAT cycles, returns the result. Define ALU_SCHED_FIXED_PRIO_EN for fixed priority.
module alu_op_scheduler #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3,
  parameter int LAT    = 1
) (
  input logic Clk,
  input logic Reset,
  alu_op_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  localparam logic [SEL_W-1:0] FIRST_ILLEGAL = SEL_W'(4);
  localparam logic [3:0]       LAT_LOAD      = 4'(LAT);

  state_t           state;
  logic [3:0]       count;
  logic             winner_q;
  logic             req_any;
  logic             grant;
  logic             accept;
  logic [SEL_W-1:0] sel_in;

`ifndef ALU_SCHED_FIXED_PRIO_EN
  logic last_grant;
`endif

  assign req_any = bus.Req0_Valid | bus.Req1_Valid;

  // grant: 0 selects requester 0, 1 selects requester 1
  always_comb begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
    grant = ~bus.Req0_Valid;
`else
    if (bus.Req0_Valid && bus.Req1_Valid) grant = ~last_grant;
    else                                  grant = bus.Req1_Valid;
`endif
  end

  assign accept         = (state == IDLE) && req_any && !Reset;
  assign sel_in         = grant ? bus.Req1_Op : bus.Req0_Op;
  assign bus.Req0_Ready = accept & ~grant;
  assign bus.Req1_Ready = accept & grant;
  assign bus.Dbg_State  = state;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= IDLE;
      count          <= 4'd0;
      winner_q       <= 1'b0;
`ifndef ALU_SCHED_FIXED_PRIO_EN
      last_grant     <= 1'b1;
`endif
      bus.Alu_Select <= '0;
      bus.Alu_Flag   <= 1'b0;
      bus.Rsp0_Valid <= 1'b0;
      bus.Rsp1_Valid <= 1'b0;
      bus.Rsp0_Data  <= '0;
      bus.Rsp1_Data  <= '0;
      bus.Rsp_Err    <= 1'b0;
      bus.Busy       <= 1'b0;
    end else begin
      bus.Rsp0_Valid <= 1'b0;
      bus.Rsp1_Valid <= 1'b0;
      bus.Rsp_Err    <= 1'b0;
      bus.Alu_Flag   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            winner_q <= grant;
`ifndef ALU_SCHED_FIXED_PRIO_EN
            last_grant <= grant;
`endif
            bus.Busy <= 1'b1;
            // illegal codes skip the ALU entirely and answer next cycle
            if (sel_in >= FIRST_ILLEGAL) begin
              state       <= RESP;
              bus.Rsp_Err <= 1'b1;
              if (grant) begin
                bus.Rsp1_Valid <= 1'b1;
                bus.Rsp1_Data  <= '0;
              end else begin
                bus.Rsp0_Valid <= 1'b1;
                bus.Rsp0_Data  <= '0;
              end
            end else begin
              state          <= ISSUE;
              bus.Alu_Select <= sel_in;
              bus.Alu_Flag   <= 1'b1;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
          count <= LAT_LOAD;
        end
        WAIT: begin
          if (count <= 4'd1) begin
            state <= RESP;
            if (winner_q) begin
              bus.Rsp1_Valid <= 1'b1;
              bus.Rsp1_Data  <= bus.Alu_Result;
            end else begin
              bus.Rsp0_Valid <= 1'b1;
              bus.Rsp0_Data  <= bus.Alu_Result;
            end
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP: begin
          state          <= IDLE;
          bus.Busy       <= 1'b0;
          bus.Alu_Select <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Bench for alu_op_scheduler: requester drivers, an ALU mux model with LAT-cycle latency,
// an event monitor and scenario tasks checked against arbitration/latency rules.
`timescale 1ns/1ps
module tb_alu_op_scheduler;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;
  localparam int LAT    = 1;
  localparam logic [DATA_W-1:0] GARB = DATA_W'('hA5);
`ifdef ALU_SCHED_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic Clk;
  logic Reset;

  alu_op_scheduler_if #(.DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();
  alu_op_scheduler #(.DATA_W(DATA_W), .SEL_W(SEL_W), .LAT(LAT)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus)
  );

  typedef struct { int cyc; logic who; logic v0; logic v1; logic [SEL_W-1:0] op; } acc_t;
  typedef struct { int cyc; logic who; logic [DATA_W-1:0] data; logic err; } rsp_t;
  typedef struct { int cyc; logic [SEL_W-1:0] sel; } flg_t;

  acc_t acc_q[$];
  rsp_t rsp_q[$];
  flg_t flg_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [SEL_W-1:0]  req0_ops[$], req1_ops[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc0_cnt = 0, acc1_cnt = 0, done0 = 0, done1 = 0;
  int dual_cnt = 0;
  int alu_k = 0;
  logic [DATA_W-1:0] alu_next, alu_val;

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // monitor and ALU mux model: result is valid for exactly one cycle, LAT cycles after ISSUE
  always @(negedge Clk) begin
    if (bus.Req0_Ready === 1'b1 || bus.Req1_Ready === 1'b1) begin
      if (bus.Req0_Ready === 1'b1 && bus.Req1_Ready === 1'b1) dual_cnt++;
      acc_q.push_back('{cyc, bus.Req1_Ready, bus.Req0_Valid, bus.Req1_Valid,
                        bus.Req1_Ready ? bus.Req1_Op : bus.Req0_Op});
      if (bus.Req0_Ready === 1'b1) acc0_cnt++;
      if (bus.Req1_Ready === 1'b1) acc1_cnt++;
    end
    if (bus.Rsp0_Valid === 1'b1 || bus.Rsp1_Valid === 1'b1) begin
      if (bus.Rsp0_Valid === 1'b1 && bus.Rsp1_Valid === 1'b1) dual_cnt++;
      rsp_q.push_back('{cyc, bus.Rsp1_Valid, bus.Rsp1_Valid ? bus.Rsp1_Data : bus.Rsp0_Data,
                        bus.Rsp_Err});
    end
    if (bus.Alu_Flag === 1'b1) begin
      flg_q.push_back('{cyc, bus.Alu_Select});
      alu_val  = alu_next;
      alu_next = DATA_W'($urandom);
      exp_q.push_back(alu_val);
      alu_k = LAT;
      bus.Alu_Result = alu_val ^ GARB;
    end else if (alu_k > 0) begin
      alu_k--;
      bus.Alu_Result = (alu_k == 0) ? alu_val : (alu_val ^ GARB);
    end else begin
      bus.Alu_Result = alu_val ^ GARB;
    end
  end

  // requester drivers: hold Valid/Op until accepted, then present the next queued op
  always @(posedge Clk) begin
    #1;
    if (acc0_cnt != done0) begin
      done0 = acc0_cnt;
      if (req0_ops.size() > 0) bus.Req0_Op = req0_ops.pop_front();
      else bus.Req0_Valid = 1'b0;
    end else if (!bus.Req0_Valid && req0_ops.size() > 0) begin
      bus.Req0_Valid = 1'b1;
      bus.Req0_Op    = req0_ops.pop_front();
    end
    if (acc1_cnt != done1) begin
      done1 = acc1_cnt;
      if (req1_ops.size() > 0) bus.Req1_Op = req1_ops.pop_front();
      else bus.Req1_Valid = 1'b0;
    end else if (!bus.Req1_Valid && req1_ops.size() > 0) begin
      bus.Req1_Valid = 1'b1;
      bus.Req1_Op    = req1_ops.pop_front();
    end
  end

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_q.delete();
    rsp_q.delete();
    flg_q.delete();
    exp_q.delete();
    dual_cnt = 0;
  endtask

  task automatic reset_dut();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    tick();
    clear_logs();
  endtask

  task automatic wait_acc(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (acc_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rsp(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (rsp_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    tick();
    n_cmp++;
    if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
    n_cmp++;
    if ({bus.Req0_Ready, bus.Req1_Ready, bus.Rsp0_Valid, bus.Rsp1_Valid, bus.Rsp_Err, bus.Alu_Flag} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b want 000000",
               {bus.Req0_Ready, bus.Req1_Ready, bus.Rsp0_Valid, bus.Rsp1_Valid, bus.Rsp_Err, bus.Alu_Flag});
    end
    n_cmp++;
    if (bus.Alu_Select !== '0) begin n_fail++; $display("FAIL reset_select: got %0h want 0", bus.Alu_Select); end
    n_cmp++;
    if ({bus.Rsp0_Data, bus.Rsp1_Data} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %0h/%0h want 0/0", bus.Rsp0_Data, bus.Rsp1_Data);
    end
    clear_logs();
  endtask

  task automatic test_single();
    bit ok;
    int a;
    clear_logs();
    alu_next = 8'h5A;
    req0_ops.push_back(3'b001);
    wait_acc(1, 20, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL single_accept: got no accept want accept"); end
    else begin
      a = acc_q[0].cyc;
      n_cmp++;
      if (acc_q[0].who !== 1'b0) begin n_fail++; $display("FAIL single_who: got %b want 0", acc_q[0].who); end
      tick();
      n_cmp++;
      if ({bus.Alu_Flag, bus.Alu_Select, bus.Busy} !== {1'b1, 3'b001, 1'b1}) begin
        n_fail++; $display("FAIL single_issue: got flag %b sel %b busy %b want 1 001 1",
                           bus.Alu_Flag, bus.Alu_Select, bus.Busy);
      end
      tick();
      n_cmp++;
      if ({bus.Alu_Flag, bus.Alu_Select} !== {1'b0, 3'b001}) begin
        n_fail++; $display("FAIL single_wait: got flag %b sel %b want 0 001", bus.Alu_Flag, bus.Alu_Select);
      end
      wait_rsp(1, 40, ok);
      n_cmp++;
      if (!ok) begin n_fail++; $display("FAIL single_rsp: got no response want response"); end
      else begin
        n_cmp++;
        if (rsp_q[0].cyc !== a + LAT + 2) begin
          n_fail++; $display("FAIL single_latency: got %0d want %0d", rsp_q[0].cyc - a, LAT + 2);
        end
        n_cmp++;
        if ({rsp_q[0].who, rsp_q[0].data, rsp_q[0].err} !== {1'b0, 8'h5A, 1'b0}) begin
          n_fail++; $display("FAIL single_rsp_data: got who %b data %h err %b want 0 5a 0",
                             rsp_q[0].who, rsp_q[0].data, rsp_q[0].err);
        end
        tick();
        n_cmp++;
        if ({bus.Busy, bus.Alu_Select, bus.Rsp0_Valid, bus.Rsp0_Data} !== {1'b0, 3'b000, 1'b0, 8'h5A}) begin
          n_fail++; $display("FAIL single_after: got busy %b sel %b v %b data %h want 0 000 0 5a",
                             bus.Busy, bus.Alu_Select, bus.Rsp0_Valid, bus.Rsp0_Data);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic exp_w;
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      req0_ops.push_back(SEL_W'($urandom_range(0, 3)));
      req1_ops.push_back(SEL_W'($urandom_range(0, 3)));
    end
    wait_rsp(6, 6 * (LAT + 3) + 20, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL rr_done: got %0d responses want 6", rsp_q.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        exp_w = FIXED_PRIO ? (i >= 3) : ((i % 2) == 1);
        n_cmp++;
        if (acc_q[i].who !== exp_w) begin
          n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", i, acc_q[i].who, exp_w);
        end
        n_cmp++;
        if ({rsp_q[i].who, rsp_q[i].data, rsp_q[i].err} !== {acc_q[i].who, exp_q[i], 1'b0}) begin
          n_fail++; $display("FAIL rr_rsp[%0d]: got who %b data %h err %b want %b %h 0", i,
                             rsp_q[i].who, rsp_q[i].data, rsp_q[i].err, acc_q[i].who, exp_q[i]);
        end
        if (i > 0) begin
          n_cmp++;
          if (acc_q[i].cyc - acc_q[i-1].cyc !== LAT + 3) begin
            n_fail++; $display("FAIL rr_spacing[%0d]: got %0d want %0d", i,
                               acc_q[i].cyc - acc_q[i-1].cyc, LAT + 3);
          end
        end
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_illegal();
    bit ok;
    clear_logs();
    req1_ops.push_back(3'b110);
    wait_rsp(1, 20, ok);
    n_cmp++;
    if (!ok || acc_q.size() != 1) begin n_fail++; $display("FAIL illegal_rsp: got %0d responses want 1", rsp_q.size()); end
    else begin
      n_cmp++;
      if (rsp_q[0].cyc - acc_q[0].cyc !== 1) begin
        n_fail++; $display("FAIL illegal_latency: got %0d want 1", rsp_q[0].cyc - acc_q[0].cyc);
      end
      n_cmp++;
      if ({acc_q[0].who, rsp_q[0].who, rsp_q[0].data, rsp_q[0].err} !== {1'b1, 1'b1, 8'h00, 1'b1}) begin
        n_fail++; $display("FAIL illegal_fields: got acc %b rsp %b data %h err %b want 1 1 00 1",
                           acc_q[0].who, rsp_q[0].who, rsp_q[0].data, rsp_q[0].err);
      end
      n_cmp++;
      if ({bus.Alu_Flag, bus.Alu_Select} !== 4'b0) begin
        n_fail++; $display("FAIL illegal_alu: got flag %b sel %b want 0 000", bus.Alu_Flag, bus.Alu_Select);
      end
    end
    repeat (3) tick();
    n_cmp++;
    if (flg_q.size() != 0) begin n_fail++; $display("FAIL illegal_flag: got %0d flag pulses want 0", flg_q.size()); end
  endtask

  task automatic test_busy_hold();
    bit ok;
    clear_logs();
    req1_ops.push_back(SEL_W'($urandom_range(0, 3)));
    wait_acc(1, 20, ok);
    tick();
    req0_ops.push_back(SEL_W'($urandom_range(0, 3)));
    wait_rsp(2, 4 * (LAT + 3) + 20, ok);
    n_cmp++;
    if (!ok || acc_q.size() != 2) begin
      n_fail++; $display("FAIL hold_count: got %0d accepts want 2", acc_q.size());
    end else begin
      n_cmp++;
      if ({acc_q[0].who, acc_q[1].who} !== 2'b10) begin
        n_fail++; $display("FAIL hold_order: got %b%b want 10", acc_q[0].who, acc_q[1].who);
      end
      n_cmp++;
      if (acc_q[1].cyc !== rsp_q[0].cyc + 1) begin
        n_fail++; $display("FAIL hold_first_idle: got accept at %0d want %0d", acc_q[1].cyc, rsp_q[0].cyc + 1);
      end
      n_cmp++;
      if (rsp_q[1].data !== exp_q[1]) begin
        n_fail++; $display("FAIL hold_data: got %h want %h", rsp_q[1].data, exp_q[1]);
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs();
    req1_ops.push_back(3'b011);
    wait_acc(1, 20, ok);
    tick();
    tick();
    n_cmp++;
    if ({bus.Busy, bus.Alu_Flag} !== 2'b10) begin
      n_fail++; $display("FAIL midreset_inwait: got busy %b flag %b want 1 0", bus.Busy, bus.Alu_Flag);
    end
    Reset = 1'b1;
    tick();
    n_cmp++;
    if ({bus.Busy, bus.Alu_Flag, bus.Rsp0_Valid, bus.Rsp1_Valid, bus.Alu_Select} !== 7'b0) begin
      n_fail++; $display("FAIL midreset_idle: got busy %b flag %b rv %b%b sel %b want all 0",
                         bus.Busy, bus.Alu_Flag, bus.Rsp0_Valid, bus.Rsp1_Valid, bus.Alu_Select);
    end
    Reset = 1'b0;
    repeat (LAT + 4) tick();
    n_cmp++;
    if (rsp_q.size() != 0) begin n_fail++; $display("FAIL midreset_norsp: got %0d responses want 0", rsp_q.size()); end
    clear_logs();
    req1_ops.push_back(SEL_W'($urandom_range(0, 3)));
    wait_rsp(1, 40, ok);
    n_cmp++;
    if (!ok || acc_q.size() != 1) begin n_fail++; $display("FAIL midreset_recover: got %0d responses want 1", rsp_q.size()); end
    else begin
      n_cmp++;
      if ({rsp_q[0].cyc - acc_q[0].cyc, rsp_q[0].who, rsp_q[0].data, rsp_q[0].err} !==
          {LAT + 2, 1'b1, exp_q[0], 1'b0}) begin
        n_fail++; $display("FAIL midreset_rsp: got lat %0d who %b data %h err %b want %0d 1 %h 0",
                           rsp_q[0].cyc - acc_q[0].cyc, rsp_q[0].who, rsp_q[0].data, rsp_q[0].err,
                           LAT + 2, exp_q[0]);
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_random();
    bit ok;
    int n0, n1, total, fi, ei;
    logic last, exp_w, legal;
    logic [SEL_W-1:0] op, exp_op;
    logic [DATA_W-1:0] exp_d;
    logic [SEL_W-1:0] ref0[$], ref1[$];
    for (int round = 0; round < 3; round++) begin
      reset_dut();
      ref0.delete();
      ref1.delete();
      n0 = $urandom_range(3, 8);
      n1 = $urandom_range(3, 8);
      for (int i = 0; i < n0; i++) begin op = SEL_W'($urandom_range(0, 7)); req0_ops.push_back(op); ref0.push_back(op); end
      for (int i = 0; i < n1; i++) begin op = SEL_W'($urandom_range(0, 7)); req1_ops.push_back(op); ref1.push_back(op); end
      total = n0 + n1;
      wait_rsp(total, total * (LAT + 3) + 20, ok);
      repeat (2) tick();
      n_cmp++;
      if (!ok || acc_q.size() != total) begin
        n_fail++; $display("FAIL rand_count: got %0d/%0d accepts/responses want %0d", acc_q.size(), rsp_q.size(), total);
      end else begin
        last = 1'b1;
        fi = 0;
        ei = 0;
        for (int i = 0; i < total; i++) begin
          exp_w = (acc_q[i].v0 && acc_q[i].v1) ? (FIXED_PRIO ? 1'b0 : ~last) : acc_q[i].v1;
          last = exp_w;
          n_cmp++;
          if (acc_q[i].who !== exp_w) begin n_fail++; $display("FAIL rand_grant[%0d]: got %b want %b", i, acc_q[i].who, exp_w); end
          exp_op = (acc_q[i].who && ref1.size() > 0) ? ref1.pop_front() :
                   (!acc_q[i].who && ref0.size() > 0) ? ref0.pop_front() : 'x;
          n_cmp++;
          if (acc_q[i].op !== exp_op) begin n_fail++; $display("FAIL rand_op[%0d]: got %b want %b", i, acc_q[i].op, exp_op); end
          legal = (acc_q[i].op < 4);
          exp_d = '0;
          if (legal) begin
            n_cmp++;
            if (fi >= flg_q.size() || flg_q[fi].cyc !== acc_q[i].cyc + 1 || flg_q[fi].sel !== acc_q[i].op) begin
              n_fail++; $display("FAIL rand_issue[%0d]: got no matching Alu_Flag pulse want cycle %0d sel %b",
                                 i, acc_q[i].cyc + 1, acc_q[i].op);
            end
            fi++;
            exp_d = (ei < exp_q.size()) ? exp_q[ei] : 'x;
            ei++;
          end
          n_cmp++;
          if (rsp_q[i].cyc - acc_q[i].cyc !== (legal ? LAT + 2 : 1)) begin
            n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, rsp_q[i].cyc - acc_q[i].cyc, legal ? LAT + 2 : 1);
          end
          n_cmp++;
          if ({rsp_q[i].who, rsp_q[i].data, rsp_q[i].err} !== {acc_q[i].who, exp_d, ~legal}) begin
            n_fail++; $display("FAIL rand_rsp[%0d]: got who %b data %h err %b want %b %h %b", i,
                               rsp_q[i].who, rsp_q[i].data, rsp_q[i].err, acc_q[i].who, exp_d, ~legal);
          end
          if (i > 0) begin
            n_cmp++;
            if (acc_q[i].cyc !== rsp_q[i-1].cyc + 1) begin
              n_fail++; $display("FAIL rand_b2b[%0d]: got accept at %0d want %0d", i, acc_q[i].cyc, rsp_q[i-1].cyc + 1);
            end
          end
        end
        n_cmp++;
        if (flg_q.size() != fi || dual_cnt != 0) begin
          n_fail++; $display("FAIL rand_extra: got %0d flags %0d dual strobes want %0d 0", flg_q.size(), dual_cnt, fi);
        end
      end
    end
  endtask

  initial begin
    Reset          = 1'b1;
    bus.Req0_Valid = 1'b0;
    bus.Req0_Op    = '0;
    bus.Req1_Valid = 1'b0;
    bus.Req1_Op    = '0;
    alu_val        = '0;
    alu_next       = DATA_W'($urandom);
    test_reset();
    test_single();
    test_round_robin();
    test_illegal();
    test_busy_hold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
